mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 34 +++
 rtl/mem_arbiter_align.sv | 61 ++++++
 rtl/mem_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: FSM/grant encodings, load/store
// width codes, the LOAD/STORE opcodes and the NOP instruction word.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DATA  = 2'd2
   } state_t;

   typedef enum logic {
      GNT_FETCH = 1'b0,
      GNT_DATA  = 1'b1
   } grant_t;

   localparam logic [6:0] OPC_LOAD  = 7'b000_0011;
   localparam logic [6:0] OPC_STORE = 7'b010_0011;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [31:0] INSN_NOP = 32'h0000_0013;

   function automatic logic [31:0] word_addr(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/mem_arbiter_align.sv
// Combinational lane logic: byte enables, store lane replication,
// load extraction with sign/zero extension, and the alignment check.
module mem_align
   import mem_arbiter_pkg::*;
(
   input  logic [2:0]  func_3,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_lanes,
   output logic [31:0] load_data,
   output logic        misaligned
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Select the addressed byte and half-word out of the read word
   always_comb begin
      byte_s = 8'h00;
      case (offset)
         2'b00:   byte_s = rdata[7:0];
         2'b01:   byte_s = rdata[15:8];
         2'b10:   byte_s = rdata[23:16];
         2'b11:   byte_s = rdata[31:24];
         default: byte_s = 8'h00;
      endcase
      half_s = offset[1] ? rdata[31:16] : rdata[15:0];
   end

   // Width decode; store codes share encodings with the signed load codes
   always_comb begin
      be          = 4'b1111;
      wdata_lanes = wdata;
      load_data   = rdata;
      misaligned  = 1'b0;
      case (func_3)
         F3_LB, F3_LBU: begin
            be          = 4'b0001 << offset;
            wdata_lanes = {4{wdata[7:0]}};
            load_data   = (func_3 == F3_LB) ? {{24{byte_s[7]}}, byte_s}
                                            : {24'h00_0000, byte_s};
         end
         F3_LH, F3_LHU: begin
            be          = 4'b0011 << offset;
            wdata_lanes = {2{wdata[15:0]}};
            load_data   = (func_3 == F3_LH) ? {{16{half_s[15]}}, half_s}
                                            : {16'h0000, half_s};
            misaligned  = offset[0];
         end
         F3_LW: begin
            misaligned = (offset != 2'b00);
         end
         default: begin
            misaligned = (offset != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store requests onto one memory port,
// with alternating priority, misalignment handling and a wait watchdog.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_valid,
   output logic [31:0] if_rdata,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [2:0]  dm_func_3,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic        dm_ready,
   output logic [31:0] dm_rdata,
   output logic        dm_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        pipe_stall
);

   localparam int unsigned WCW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

   state_t         state_r, state_s;
   grant_t         last_r, last_s;
   logic [WCW-1:0] wait_r, wait_s;
   logic           mem_req_r, mem_req_s;
   logic           mem_we_r, mem_we_s;
   logic [31:0]    mem_addr_r, mem_addr_s;
   logic [31:0]    mem_wdata_r, mem_wdata_s;
   logic [3:0]     mem_be_r, mem_be_s;
   logic           if_valid_r, if_valid_s;
   logic [31:0]    if_rdata_r, if_rdata_s;
   logic           dm_ready_r, dm_ready_s;
   logic [31:0]    dm_rdata_r, dm_rdata_s;
   logic           dm_err_r, dm_err_s;

   logic           dm_pend_s, if_pend_s, pick_data_s, pick_fetch_s;
   logic [3:0]     be_s;
   logic [31:0]    lanes_s, load_s;
   logic           dm_mis_s;

   mem_align u_align (
      .func_3      (dm_func_3),
      .offset      (dm_addr[1:0]),
      .wdata       (dm_wdata),
      .rdata       (mem_rdata),
      .be          (be_s),
      .wdata_lanes (lanes_s),
      .load_data   (load_s),
      .misaligned  (dm_mis_s)
   );

   // A requester whose completion pulse is out this cycle is not pending again
   always_comb begin
      dm_pend_s    = dm_req & ~dm_ready_r;
      if_pend_s    = if_req & ~if_valid_r;
      pick_data_s  = dm_pend_s & ~((last_r == GNT_DATA) & if_pend_s);
      pick_fetch_s = if_pend_s & ~pick_data_s;
      pipe_stall   = dm_pend_s | if_pend_s;
   end

   // Next-state and next-output logic; everything lands in registers
   always_comb begin
      state_s     = state_r;
      last_s      = last_r;
      wait_s      = wait_r;
      mem_req_s   = mem_req_r;
      mem_we_s    = mem_we_r;
      mem_addr_s  = mem_addr_r;
      mem_wdata_s = mem_wdata_r;
      mem_be_s    = mem_be_r;
      if_valid_s  = 1'b0;
      if_rdata_s  = if_rdata_r;
      dm_ready_s  = 1'b0;
      dm_rdata_s  = dm_rdata_r;
      dm_err_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            wait_s    = '0;
            mem_req_s = 1'b0;
            if (pick_data_s) begin
               last_s = GNT_DATA;
               if (dm_mis_s) begin
                  dm_ready_s = 1'b1;
                  dm_err_s   = 1'b1;
                  dm_rdata_s = 32'h0000_0000;
               end else begin
                  state_s     = ST_DATA;
                  mem_req_s   = 1'b1;
                  mem_we_s    = dm_we;
                  mem_addr_s  = word_addr(dm_addr);
                  mem_wdata_s = lanes_s;
                  mem_be_s    = be_s;
               end
            end else if (pick_fetch_s) begin
               last_s = GNT_FETCH;
               if (if_addr[1:0] != 2'b00) begin
                  if_valid_s = 1'b1;
                  if_rdata_s = INSN_NOP;
               end else begin
                  state_s     = ST_FETCH;
                  mem_req_s   = 1'b1;
                  mem_we_s    = 1'b0;
                  mem_addr_s  = word_addr(if_addr);
                  mem_wdata_s = 32'h0000_0000;
                  mem_be_s    = 4'b1111;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (mem_ack) begin
               state_s    = ST_IDLE;
               mem_req_s  = 1'b0;
               wait_s     = '0;
               if_valid_s = 1'b1;
               if_rdata_s = mem_rdata;
            end else if (wait_r == WAIT_LAST) begin
               state_s    = ST_IDLE;
               mem_req_s  = 1'b0;
               wait_s     = '0;
               if_valid_s = 1'b1;
               if_rdata_s = INSN_NOP;
            end else begin
               wait_s = wait_r + WCW'(1);
            end
         end
         ST_DATA: begin
            if (mem_ack) begin
               state_s    = ST_IDLE;
               mem_req_s  = 1'b0;
               wait_s     = '0;
               dm_ready_s = 1'b1;
               dm_rdata_s = mem_we_r ? 32'h0000_0000 : load_s;
            end else if (wait_r == WAIT_LAST) begin
               state_s    = ST_IDLE;
               mem_req_s  = 1'b0;
               wait_s     = '0;
               dm_ready_s = 1'b1;
               dm_err_s   = 1'b1;
               dm_rdata_s = 32'h0000_0000;
            end else begin
               wait_s = wait_r + WCW'(1);
            end
         end
         default: begin
            state_s   = ST_IDLE;
            mem_req_s = 1'b0;
            wait_s    = '0;
         end
      endcase
   end

   // State and output registers; reset abandons any transaction in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         last_r      <= GNT_FETCH;
         wait_r      <= '0;
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= 32'h0000_0000;
         mem_wdata_r <= 32'h0000_0000;
         mem_be_r    <= 4'b0000;
         if_valid_r  <= 1'b0;
         if_rdata_r  <= 32'h0000_0000;
         dm_ready_r  <= 1'b0;
         dm_rdata_r  <= 32'h0000_0000;
         dm_err_r    <= 1'b0;
      end else begin
         state_r     <= state_s;
         last_r      <= last_s;
         wait_r      <= wait_s;
         mem_req_r   <= mem_req_s;
         mem_we_r    <= mem_we_s;
         mem_addr_r  <= mem_addr_s;
         mem_wdata_r <= mem_wdata_s;
         mem_be_r    <= mem_be_s;
         if_valid_r  <= if_valid_s;
         if_rdata_r  <= if_rdata_s;
         dm_ready_r  <= dm_ready_s;
         dm_rdata_r  <= dm_rdata_s;
         dm_err_r    <= dm_err_s;
      end
   end

   assign mem_req   = mem_req_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign mem_be    = mem_be_r;
   assign if_valid  = if_valid_r;
   assign if_rdata  = if_rdata_r;
   assign dm_ready  = dm_ready_r;
   assign dm_rdata  = dm_rdata_r;
   assign dm_err    = dm_err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter with a latency-programmable memory model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_valid;
   logic [31:0] if_rdata;
   logic        dm_req;
   logic        dm_we;
   logic [2:0]  dm_func_3;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_ready;
   logic [31:0] dm_rdata;
   logic        dm_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'h0000_0000;
   logic        pipe_stall;

   mem_arbiter #(.MAX_WAIT(16)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_func_3(dm_func_3), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata), .dm_err(dm_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .pipe_stall(pipe_stall)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        is_data;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int vectors = 0;
   int miscompares = 0;

   // memory model knobs (written by the stimulus only)
   bit          ack_en = 1'b1;
   bit          force_ack = 1'b0;
   int          lat = 0;
   logic [31:0] mem_word = 32'h0000_0000;

   // memory model state (written by the model only)
   int          req_total = 0;
   int          lat_cnt = 0;
   bit          in_txn = 1'b0;
   logic [31:0] cap_addr, cap_wdata;
   logic [3:0]  cap_be;
   logic        cap_we;

   always @(negedge clk) begin
      if (mem_req) begin
         req_total = req_total + 1;
         if (!in_txn) begin
            cap_addr  = mem_addr;
            cap_wdata = mem_wdata;
            cap_be    = mem_be;
            cap_we    = mem_we;
         end
         in_txn = 1'b1;
      end else begin
         in_txn = 1'b0;
      end
      if (force_ack) begin
         mem_ack   = 1'b1;
         mem_rdata = mem_word;
      end else if (mem_req && ack_en) begin
         if (lat_cnt >= lat) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_word;
            lat_cnt   = 0;
         end else begin
            mem_ack = 1'b0;
            lat_cnt = lat_cnt + 1;
         end
      end else begin
         mem_ack = 1'b0;
         lat_cnt = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input string tag, input bit drop, output int cyc);
      exp_t e;
      bit   seen;
      seen = 1'b0;
      cyc  = -1;
      for (int c = 0; c < 64 && !seen; c++) begin
         @(negedge clk);
         if (if_valid || dm_ready) begin
            seen = 1'b1;
            cyc  = c;
            if (exp_q.size() == 0) begin
               check({tag, "_sb_empty"}, 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check({tag, "_kind"}, 32'(dm_ready), 32'(e.is_data));
               check({tag, "_rdata"}, dm_ready ? dm_rdata : if_rdata, e.rdata);
               check({tag, "_err"}, 32'(dm_err), 32'(e.err));
            end
            if (drop) begin
               if_req = 1'b0;
               dm_req = 1'b0;
            end
         end else begin
            check({tag, "_stall"}, 32'(pipe_stall), 32'd1);
         end
      end
      vectors++;
      assert (seen) else begin
         miscompares++;
         $error("FAIL %s_timeout observed=no_completion expected=completion", tag);
         if_req = 1'b0;
         dm_req = 1'b0;
      end
   endtask

   task automatic do_data(input string tag, input logic [2:0] f3, input logic we,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          output int cyc, output int ncyc);
      int base;
      @(negedge clk);
      base      = req_total;
      dm_req    = 1'b1;
      dm_we     = we;
      dm_func_3 = f3;
      dm_addr   = a;
      dm_wdata  = wd;
      exp_q.push_back('{1'b1, exp_rd, exp_err});
      wait_done(tag, 1'b1, cyc);
      ncyc = req_total - base;
   endtask

   task automatic do_fetch(input string tag, input logic [31:0] a, input logic [31:0] exp_rd,
                           output int cyc, output int ncyc);
      int base;
      @(negedge clk);
      base    = req_total;
      if_req  = 1'b1;
      if_addr = a;
      exp_q.push_back('{1'b0, exp_rd, 1'b0});
      wait_done(tag, 1'b1, cyc);
      ncyc = req_total - base;
   endtask

   initial begin
      int  cyc, ncyc;
      bit  found;
      reset = 1'b1; if_req = 1'b0; if_addr = 32'h0; dm_req = 1'b0; dm_we = 1'b0;
      dm_func_3 = 3'b000; dm_addr = 32'h0; dm_wdata = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_if_valid", 32'(if_valid), 32'd0);
      check("rst_dm_ready", 32'(dm_ready), 32'd0);
      check("rst_dm_err", 32'(dm_err), 32'd0);
      check("rst_mem_be", 32'(mem_be), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("idle_stall", 32'(pipe_stall), 32'd0);

      // fetch with single-cycle memory
      lat = 0; mem_word = 32'h0050_0093;
      do_fetch("fetch100", 32'h0000_0100, 32'h0050_0093, cyc, ncyc);
      check("fetch100_reqcyc", ncyc, 32'd1);
      check("fetch100_addr", cap_addr, 32'h0000_0100);
      check("fetch100_we", 32'(cap_we), 32'd0);

      // loads with extension
      lat = 2; mem_word = 32'h80FF_FF7F;
      do_data("lb203", 3'b000, 1'b0, 32'h0000_0203, 32'h0, 32'hFFFF_FF80, 1'b0, cyc, ncyc);
      check("lb203_addr", cap_addr, 32'h0000_0200);
      check("lb203_reqcyc", ncyc, 32'd3);
      do_data("lbu203", 3'b100, 1'b0, 32'h0000_0203, 32'h0, 32'h0000_0080, 1'b0, cyc, ncyc);
      do_data("lh202", 3'b001, 1'b0, 32'h0000_0202, 32'h0, 32'hFFFF_80FF, 1'b0, cyc, ncyc);
      do_data("lhu200", 3'b101, 1'b0, 32'h0000_0200, 32'h0, 32'h0000_FF7F, 1'b0, cyc, ncyc);
      lat = 1; mem_word = 32'hCAFE_F00D;
      do_data("lw204", 3'b010, 1'b0, 32'h0000_0204, 32'h0, 32'hCAFE_F00D, 1'b0, cyc, ncyc);

      // stores: byte enables and lane replication
      do_data("sh002", 3'b001, 1'b1, 32'h0000_0002, 32'h1234_ABCD, 32'h0, 1'b0, cyc, ncyc);
      check("sh002_be", 32'(cap_be), 32'h0000_000C);
      check("sh002_wdata", cap_wdata, 32'hABCD_ABCD);
      check("sh002_addr", cap_addr, 32'h0000_0000);
      check("sh002_we", 32'(cap_we), 32'd1);
      do_data("sb201", 3'b000, 1'b1, 32'h0000_0201, 32'h0000_005A, 32'h0, 1'b0, cyc, ncyc);
      check("sb201_be", 32'(cap_be), 32'h0000_0002);
      check("sb201_wdata", cap_wdata, 32'h5A5A_5A5A);
      do_data("sw010", 3'b010, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, cyc, ncyc);
      check("sw010_be", 32'(cap_be), 32'h0000_000F);
      check("sw010_wdata", cap_wdata, 32'hDEAD_BEEF);

      // misaligned accesses: no memory cycle, completion right after the grant
      do_data("lw006", 3'b010, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 1'b1, cyc, ncyc);
      check("lw006_reqcyc", ncyc, 32'd0);
      check("lw006_latency", cyc, 32'd0);
      do_data("sh003", 3'b001, 1'b1, 32'h0000_0003, 32'h0, 32'h0, 1'b1, cyc, ncyc);
      check("sh003_reqcyc", ncyc, 32'd0);
      do_fetch("fetch102", 32'h0000_0102, 32'h0000_0013, cyc, ncyc);
      check("fetch102_reqcyc", ncyc, 32'd0);

      // watchdog aborts
      ack_en = 1'b0;
      do_data("wd_lw300", 3'b010, 1'b0, 32'h0000_0300, 32'h0, 32'h0, 1'b1, cyc, ncyc);
      check("wd_lw300_reqcyc", ncyc, 32'd16);
      do_fetch("wd_fetch104", 32'h0000_0104, 32'h0000_0013, cyc, ncyc);
      check("wd_fetch104_reqcyc", ncyc, 32'd16);

      // reset in the second DATA wait cycle
      @(negedge clk);
      dm_req = 1'b1; dm_we = 1'b0; dm_func_3 = 3'b010; dm_addr = 32'h0000_0600;
      found = 1'b0;
      for (int c = 0; c < 8 && !found; c++) begin
         @(negedge clk);
         found = mem_req;
      end
      check("rstmid_req_seen", 32'(found), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rstmid_mem_req", 32'(mem_req), 32'd0);
      check("rstmid_dm_ready", 32'(dm_ready), 32'd0);
      reset = 1'b0; dm_req = 1'b0;
      ack_en = 1'b1; force_ack = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("late_ack_dm_ready", 32'(dm_ready), 32'd0);
         check("late_ack_if_valid", 32'(if_valid), 32'd0);
         check("late_ack_mem_req", 32'(mem_req), 32'd0);
      end
      force_ack = 1'b0;

      // simultaneous requests alternate DATA, FETCH, DATA, FETCH
      lat = 1; mem_word = 32'h1111_2222;
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h0000_0500;
      dm_req = 1'b1; dm_we = 1'b0; dm_func_3 = 3'b010; dm_addr = 32'h0000_0400;
      exp_q.push_back('{1'b1, 32'h1111_2222, 1'b0});
      exp_q.push_back('{1'b0, 32'h1111_2222, 1'b0});
      exp_q.push_back('{1'b1, 32'h1111_2222, 1'b0});
      exp_q.push_back('{1'b0, 32'h1111_2222, 1'b0});
      wait_done("alt1", 1'b0, cyc);
      wait_done("alt2", 1'b0, cyc);
      wait_done("alt3", 1'b0, cyc);
      wait_done("alt4", 1'b1, cyc);
      check("sb_drained", exp_q.size(), 32'd0);
      repeat (3) @(negedge clk);
      check("final_mem_req", 32'(mem_req), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
